// File: rtl/module_fetch_ctrl.sv
// module_fetch_ctrl
// Instruction fetch sequencer. Owns the architectural PC, issues word fetches
// to instruction memory over req/ack and presents each fetched word to decode
// over valid/ready. Execute can redirect the PC with a branch or jump. A
// conditional branch is resolved against the zero flag.
//
// Fetch states:
//   S_IDLE  : one cycle after reset, no request outstanding
//   S_FETCH : request for pc outstanding
//   S_DROP  : a redirect arrived while a request was outstanding; wait for
//             the ack, discard the word, then fetch the new pc
//   S_HOLD  : fetched word presented to decode until it is consumed
//
// Every output comes straight from a flop. The next-state logic computes the
// upcoming request and valid flags so that they can be registered.
module module_fetch_ctrl #(
    parameter int unsigned          WORD_SIZE  = 32,
    parameter logic [WORD_SIZE-1:0] RESET_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    // instruction memory port
    output logic                 imem_req,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    // decode port
    output logic                 instr_valid,
    output logic [WORD_SIZE-1:0] instr,
    output logic [WORD_SIZE-1:0] instr_pc,
    input  logic                 instr_ready,
    // control transfer from execute
    input  logic                 br_valid,
    input  logic [1:0]           br_type,
    input  logic [WORD_SIZE-1:0] br_target,
    input  logic                 zero_fg,
    // status
    output logic [WORD_SIZE-1:0] pc_out,
    output logic                 redirect,
    output logic [15:0]          taken_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_DROP  = 2'b10,
        S_HOLD  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        BR_BEQ  = 2'b00,
        BR_BNE  = 2'b01,
        BR_JUMP = 2'b10,
        BR_RSVD = 2'b11
    } br_type_e;

    // The PC always advances by one word. Branch targets are forced to word alignment.
    localparam logic [WORD_SIZE-1:0] PC_STEP    = WORD_SIZE'(4);
    localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~WORD_SIZE'(3);

    // Registered state
    state_e                 state_q;
    logic [WORD_SIZE-1:0]   pc_q;
    logic [WORD_SIZE-1:0]   addr_q;
    logic                   req_q;
    logic                   valid_q;
    logic [WORD_SIZE-1:0]   instr_q;
    logic [WORD_SIZE-1:0]   instr_pc_q;
    logic                   redirect_q;
    logic [15:0]            count_q;

    // Next-state values
    state_e                 state_d;
    logic [WORD_SIZE-1:0]   pc_d;
    logic [WORD_SIZE-1:0]   addr_d;
    logic                   capture;
    logic                   br_cond;
    logic                   taken;
    logic [WORD_SIZE-1:0]   target_aligned;

    assign target_aligned = br_target & ALIGN_MASK;

    // Resolve the branch condition from br_type and the zero flag.
    always_comb begin
        // NOTE: every signal written here gets a default first. A path that
        // leaves a signal unassigned would infer a latch.
        br_cond = 1'b0;
        case (br_type_e'(br_type))
            BR_BEQ:  br_cond = zero_fg;
            BR_BNE:  br_cond = ~zero_fg;
            BR_JUMP: br_cond = 1'b1;
            BR_RSVD: br_cond = 1'b0;
            default: br_cond = 1'b0;
        endcase
    end

    // A request presented in S_IDLE is ignored. In every other state, a request whose condition holds is taken.
    assign taken = br_valid && br_cond && (state_q != S_IDLE);

    // Compute the next state, the next PC, the fetch address, and the instruction capture.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        capture = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (taken) begin
                    // If the word comes back in this same cycle, it is already
                    // dead and the target can be fetched at once. Otherwise the
                    // request must be completed first.
                    state_d = imem_ack ? S_FETCH : S_DROP;
                end else if (imem_ack) begin
                    state_d = S_HOLD;
                    capture = 1'b1;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    state_d = S_FETCH;
                end
            end
            S_HOLD: begin
                if (taken || instr_ready) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A taken branch takes priority over consumption. The held word is
        // discarded and the PC does not advance by a word.
        if (taken) begin
            pc_d = target_aligned;
        end else if (state_q == S_HOLD && instr_ready) begin
            pc_d = pc_q + PC_STEP;
        end

        // Each new fetch presents the upcoming PC. While a request is in flight
        // (S_DROP, or S_FETCH waiting), the address stays unchanged.
        if (state_d == S_FETCH) begin
            addr_d = pc_d;
        end
    end

    // Update the state register and the registered handshake outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop
        // samples the values from before the edge. Blocking assignments here
        // would make the result depend on statement order.
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_ADDR;
            addr_q  <= RESET_ADDR;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= (state_d == S_FETCH) || (state_d == S_DROP);
            valid_q <= (state_d == S_HOLD);
        end
    end

    // Capture the returned instruction word and the address it came from.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else if (capture) begin
            instr_q    <= imem_rdata;
            instr_pc_q <= pc_q;
        end
    end

    // Generate the redirect pulse and count taken redirects. The count wraps at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_q <= 1'b0;
            count_q    <= '0;
        end else begin
            redirect_q <= taken;
            if (taken) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc_out      = pc_q;
    assign redirect    = redirect_q;
    assign taken_count = count_q;

endmodule

// File: tb/tb_module_fetch_ctrl.sv
// tb_module_fetch_ctrl
// Directed scenarios for each fetch feature, then a randomized run checked
// against a rule-level model of PC, handshake and redirect behaviour.
module tb_module_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        br_valid;
    logic [1:0]  br_type;
    logic [31:0] br_target;
    logic        zero_fg;
    logic [31:0] pc_out;
    logic        redirect;
    logic [15:0] taken_count;

    int checks   = 0;
    int failures = 0;

    module_fetch_ctrl #(.WORD_SIZE(32), .RESET_ADDR(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .br_valid    (br_valid),
        .br_type     (br_type),
        .br_target   (br_target),
        .zero_fg     (zero_fg),
        .pc_out      (pc_out),
        .redirect    (redirect),
        .taken_count (taken_count)
    );

    always #5 clk = ~clk;

    // Memory contents are a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        br_valid    = 1'b0;
        br_type     = 2'b00;
        br_target   = 32'h0;
        zero_fg     = 1'b0;
    endtask

    // Hold reset for two edges. On return the DUT is in its first cycle after reset.
    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // The memory responder acks the current request when ok=1.
    task automatic respond(input bit ok);
        imem_ack   = imem_req & ok;
        imem_rdata = mem_word(imem_addr);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        br_valid = 1'b1; br_type = 2'b10; br_target = 32'h500;
        tick();
        checks++; if ({imem_req, instr_valid, redirect} !== 3'b000) begin failures++;
            $display("FAIL reset_flags got=%b want=000", {imem_req, instr_valid, redirect}); end
        checks++; if (pc_out !== 32'h0 || imem_addr !== 32'h0) begin failures++;
            $display("FAIL reset_pc_addr got=%h/%h want=0/0", pc_out, imem_addr); end
        checks++; if (instr !== 32'h0 || instr_pc !== 32'h0 || taken_count !== 16'h0) begin failures++;
            $display("FAIL reset_data got=%h/%h/%h want=0/0/0", instr, instr_pc, taken_count); end
        // In the first cycle after reset, a jump and an ack are present. Both must be ignored.
        reset = 1'b0;
        checks++; if (imem_req !== 1'b0) begin failures++;
            $display("FAIL idle_req got=%b want=0", imem_req); end
        tick();
        checks++; if ({imem_req, instr_valid, redirect} !== 3'b100 || imem_addr !== 32'h0) begin failures++;
            $display("FAIL first_fetch got=%b addr=%h want=100 addr=0", {imem_req, instr_valid, redirect}, imem_addr); end
        checks++; if (pc_out !== 32'h0 || taken_count !== 16'h0) begin failures++;
            $display("FAIL idle_branch_ignored got pc=%h cnt=%h want pc=0 cnt=0", pc_out, taken_count); end
        idle_inputs();
    endtask

    task automatic test_sequential();
        logic [31:0] want;
        do_reset();
        instr_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            respond(1'b1);
            tick();
            if (k % 2 == 1) begin
                want = 32'((k - 1) * 2);
                checks++; if ({imem_req, instr_valid} !== 2'b10 || imem_addr !== want) begin failures++;
                    $display("FAIL seq_fetch k=%0d got=%b addr=%h want=10 addr=%h", k, {imem_req, instr_valid}, imem_addr, want); end
            end else begin
                want = 32'((k - 2) * 2);
                checks++; if ({imem_req, instr_valid} !== 2'b01 || instr_pc !== want || instr !== mem_word(want)) begin failures++;
                    $display("FAIL seq_valid k=%0d got=%b pc=%h instr=%h want=01 pc=%h instr=%h",
                             k, {imem_req, instr_valid}, instr_pc, instr, want, mem_word(want)); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        do_reset();
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin failures++;
                $display("FAIL stall_req c=%0d got req=%b addr=%h valid=%b want 1/0/0", c, imem_req, imem_addr, instr_valid); end
        end
        respond(1'b1);
        tick();
        imem_ack = 1'b0;
        for (int s = 0; s < 3; s++) begin
            checks++; if (instr_valid !== 1'b1 || instr !== mem_word(32'h0) || instr_pc !== 32'h0 || pc_out !== 32'h0) begin failures++;
                $display("FAIL stall_hold s=%0d got v=%b instr=%h ipc=%h pc=%h", s, instr_valid, instr, instr_pc, pc_out); end
            if (s == 2) instr_ready = 1'b1;
            tick();
        end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || pc_out !== 32'h4 || instr_valid !== 1'b0) begin failures++;
            $display("FAIL stall_advance got req=%b addr=%h pc=%h v=%b want 1/4/4/0", imem_req, imem_addr, pc_out, instr_valid); end
        idle_inputs();
    endtask

    task automatic test_branch_hold();
        do_reset();
        tick();
        respond(1'b1);
        tick();
        imem_ack = 1'b0; instr_ready = 1'b1;
        br_valid = 1'b1; br_type = 2'b00; zero_fg = 1'b1; br_target = 32'h103;
        tick();
        checks++; if ({imem_req, instr_valid, redirect} !== 3'b101) begin failures++;
            $display("FAIL beq_flags got=%b want=101", {imem_req, instr_valid, redirect}); end
        checks++; if (imem_addr !== 32'h100 || pc_out !== 32'h100 || taken_count !== 16'd1) begin failures++;
            $display("FAIL beq_target got addr=%h pc=%h cnt=%0d want 100/100/1", imem_addr, pc_out, taken_count); end
        idle_inputs();
        tick();
        checks++; if (redirect !== 1'b0 || taken_count !== 16'd1 || imem_addr !== 32'h100) begin failures++;
            $display("FAIL beq_pulse got redir=%b cnt=%0d addr=%h want 0/1/100", redirect, taken_count, imem_addr); end
        respond(1'b1);
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== mem_word(32'h100)) begin failures++;
            $display("FAIL beq_fetched got v=%b ipc=%h instr=%h", instr_valid, instr_pc, instr); end
        idle_inputs();
    endtask

    task automatic test_not_taken();
        do_reset();
        tick();
        respond(1'b1);
        tick();
        imem_ack = 1'b0; instr_ready = 1'b1;
        br_valid = 1'b1; br_type = 2'b01; zero_fg = 1'b1; br_target = 32'h300;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || redirect !== 1'b0 || taken_count !== 16'd0) begin failures++;
            $display("FAIL bne_not_taken got addr=%h redir=%b cnt=%0d want 4/0/0", imem_addr, redirect, taken_count); end
        respond(1'b1);
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4) begin failures++;
            $display("FAIL bne_fetch got v=%b ipc=%h want 1/4", instr_valid, instr_pc); end
        imem_ack = 1'b0; br_type = 2'b11; zero_fg = 1'b0;
        tick();
        checks++; if (imem_addr !== 32'h8 || pc_out !== 32'h8 || redirect !== 1'b0 || taken_count !== 16'd0) begin failures++;
            $display("FAIL rsvd_not_taken got addr=%h pc=%h redir=%b cnt=%0d want 8/8/0/0", imem_addr, pc_out, redirect, taken_count); end
        idle_inputs();
    endtask

    task automatic test_jump_pending();
        do_reset();
        tick();
        br_valid = 1'b1; br_type = 2'b10; br_target = 32'h40;
        tick();
        checks++; if ({imem_req, instr_valid, redirect} !== 3'b101 || imem_addr !== 32'h0) begin failures++;
            $display("FAIL jmp_drop got=%b addr=%h want=101 addr=0", {imem_req, instr_valid, redirect}, imem_addr); end
        checks++; if (pc_out !== 32'h40 || taken_count !== 16'd1) begin failures++;
            $display("FAIL jmp_pc got pc=%h cnt=%0d want 40/1", pc_out, taken_count); end
        idle_inputs();
        tick();
        checks++; if ({imem_req, instr_valid, redirect} !== 3'b100 || imem_addr !== 32'h0) begin failures++;
            $display("FAIL jmp_hold_addr got=%b addr=%h want=100 addr=0", {imem_req, instr_valid, redirect}, imem_addr); end
        respond(1'b1);
        tick();
        checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'h40) begin failures++;
            $display("FAIL jmp_discard got req=%b v=%b addr=%h want 1/0/40", imem_req, instr_valid, imem_addr); end
        respond(1'b1);
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== mem_word(32'h40)) begin failures++;
            $display("FAIL jmp_target_word got v=%b ipc=%h instr=%h", instr_valid, instr_pc, instr); end
        idle_inputs();
    endtask

    task automatic test_wrap();
        do_reset();
        tick();
        respond(1'b1);
        br_valid = 1'b1; br_type = 2'b10; br_target = 32'hFFFF_FFFE;
        tick();
        checks++; if ({imem_req, instr_valid, redirect} !== 3'b101 || imem_addr !== 32'hFFFF_FFFC || pc_out !== 32'hFFFF_FFFC) begin failures++;
            $display("FAIL wrap_jump got=%b addr=%h pc=%h want=101 fffffffc", {imem_req, instr_valid, redirect}, imem_addr, pc_out); end
        idle_inputs();
        respond(1'b1);
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin failures++;
            $display("FAIL wrap_hold got v=%b ipc=%h want 1/fffffffc", instr_valid, instr_pc); end
        imem_ack = 1'b0; instr_ready = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || pc_out !== 32'h0) begin failures++;
            $display("FAIL wrap_next got req=%b addr=%h pc=%h want 1/0/0", imem_req, imem_addr, pc_out); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        tick();
        respond(1'b1);
        br_valid = 1'b1; br_type = 2'b10; br_target = 32'h80;
        tick();
        idle_inputs();
        respond(1'b1);
        tick();
        imem_ack = 1'b0; instr_ready = 1'b1;
        tick();
        // The DUT is now fetching 0x84 with a nonzero count and a held instruction.
        instr_ready = 1'b0;
        reset = 1'b1;
        tick();
        checks++; if ({imem_req, instr_valid, redirect} !== 3'b000 || pc_out !== 32'h0 || imem_addr !== 32'h0) begin failures++;
            $display("FAIL rst_mid_ctrl got=%b pc=%h addr=%h want=000 0 0", {imem_req, instr_valid, redirect}, pc_out, imem_addr); end
        checks++; if (instr !== 32'h0 || instr_pc !== 32'h0 || taken_count !== 16'd0) begin failures++;
            $display("FAIL rst_mid_data got=%h/%h/%0d want 0/0/0", instr, instr_pc, taken_count); end
        reset = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        imem_ack = 1'b0;
        checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'h0) begin failures++;
            $display("FAIL late_ack_ignored got req=%b v=%b addr=%h want 1/0/0", imem_req, instr_valid, imem_addr); end
        tick();
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin failures++;
            $display("FAIL late_ack_no_word got v=%b req=%b want 0/1", instr_valid, imem_req); end
        idle_inputs();
    endtask

    // Rule-level model. It tracks the architectural PC, the redirect count, and
    // the handshake obligations implied by each ack, ready and taken branch.
    task automatic test_random();
        logic [31:0] m_pc, m_addr;
        logic [15:0] m_count;
        logic        m_req, m_valid, m_redir, m_idle, m_drop;
        logic        rst_i, ack_i, rdy_i, bv_i, z_i, cond, taken;
        logic        n_req, n_valid, n_drop;
        logic [1:0]  bt_i;
        logic [31:0] tgt_i;

        do_reset();
        m_pc = 32'h0; m_addr = 32'h0; m_count = 16'h0;
        m_req = 1'b0; m_valid = 1'b0; m_redir = 1'b0; m_idle = 1'b1; m_drop = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            checks++; if (pc_out !== m_pc || taken_count !== m_count) begin failures++;
                $display("FAIL rnd_pc_count n=%0d got pc=%h cnt=%0d want pc=%h cnt=%0d", n, pc_out, taken_count, m_pc, m_count); end
            checks++; if ({imem_req, instr_valid, redirect} !== {m_req, m_valid, m_redir}) begin failures++;
                $display("FAIL rnd_flags n=%0d got=%b want=%b", n, {imem_req, instr_valid, redirect}, {m_req, m_valid, m_redir}); end
            if (m_req) begin
                checks++; if (imem_addr !== m_addr) begin failures++;
                    $display("FAIL rnd_addr n=%0d got=%h want=%h", n, imem_addr, m_addr); end
            end
            if (m_valid) begin
                checks++; if (instr_pc !== m_pc || instr !== mem_word(m_pc)) begin failures++;
                    $display("FAIL rnd_instr n=%0d got ipc=%h instr=%h want ipc=%h instr=%h", n, instr_pc, instr, m_pc, mem_word(m_pc)); end
            end

            rst_i = ($urandom_range(0, 299) == 0);
            ack_i = (m_req && ($urandom_range(0, 99) < 45)) || (m_idle && ($urandom_range(0, 1) == 1));
            rdy_i = ($urandom_range(0, 99) < 60);
            bv_i  = ($urandom_range(0, 99) < 15);
            bt_i  = 2'($urandom_range(0, 3));
            z_i   = 1'($urandom_range(0, 1));
            tgt_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : 32'($urandom_range(0, 4095));
            reset       = rst_i;
            imem_ack    = ack_i;
            imem_rdata  = m_req ? mem_word(m_addr) : 32'($urandom);
            instr_ready = rdy_i;
            br_valid    = bv_i;
            br_type     = bt_i;
            zero_fg     = z_i;
            br_target   = tgt_i;

            if (rst_i) begin
                m_pc = 32'h0; m_addr = 32'h0; m_count = 16'h0;
                m_req = 1'b0; m_valid = 1'b0; m_redir = 1'b0; m_idle = 1'b1; m_drop = 1'b0;
            end else begin
                case (bt_i)
                    2'b00:   cond = z_i;
                    2'b01:   cond = ~z_i;
                    2'b10:   cond = 1'b1;
                    default: cond = 1'b0;
                endcase
                taken   = bv_i && cond && !m_idle;
                n_req   = m_idle | (m_req & ~ack_i) | (m_req & ack_i & (taken | m_drop)) | (m_valid & (rdy_i | taken));
                n_valid = (m_req & ack_i & ~m_drop & ~taken) | (m_valid & ~rdy_i & ~taken);
                n_drop  = m_req & ~ack_i & (m_drop | taken);
                if (taken) m_pc = tgt_i & 32'hFFFF_FFFC;
                else if (m_valid && rdy_i) m_pc = m_pc + 32'd4;
                if (n_req && !(m_req && !ack_i)) m_addr = m_pc;
                if (taken) m_count = m_count + 16'd1;
                m_redir = taken;
                m_req   = n_req;
                m_valid = n_valid;
                m_drop  = n_drop;
                m_idle  = 1'b0;
            end
            tick();
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_sequential();
        test_stall();
        test_branch_hold();
        test_not_taken();
        test_jump_pending();
        test_wrap();
        test_reset_mid_fetch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
